// File: rtl/keypad_matrix_scanner.sv
// -----------------------------------------------------------------------------
// keypad_matrix_scanner
//
// Scans a 4x4 passive matrix keypad. One column is driven low at a time and the
// pulled-up row lines are sampled. Rows are synchronised, one full 16-key scan
// vector is assembled, and a small FSM debounces it over whole scans. A single
// accepted key is reported as a 4-bit code, with a one-clk valid strobe and a
// held "pressed" level.
//
// Parameters
//   COUNTER_BITS   : prescaler width; one column slot lasts 2^COUNTER_BITS clks
//   DEBOUNCE_SCANS : identical consecutive scans needed to accept a press or a
//                    release (1..15)
//
// Ports
//   clk         in   system clock
//   nreset      in   asynchronous active-low reset
//   rows[3:0]   in   row lines, active low, asynchronous to clk
//   cols[3:0]   out  column drive, active low, exactly one bit low
//   key_code    out  accepted key, 4*row + col (held after release)
//   key_valid   out  one-clk pulse when a new press is accepted
//   key_pressed out  high while the accepted key is held
// -----------------------------------------------------------------------------
module keypad_matrix_scanner #(
  parameter int COUNTER_BITS   = 18,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clk,
  input  logic       nreset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_pressed
);

  localparam logic [3:0] DEB_N = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    S_IDLE        = 2'd0,
    S_DEB_PRESS   = 2'd1,
    S_PRESSED     = 2'd2,
    S_DEB_RELEASE = 2'd3
  } state_t;

  logic [3:0]              r_rows_p0;
  logic [3:0]              r_rows_p1;
  logic [COUNTER_BITS-1:0] r_presc;
  logic [1:0]              r_col;
  logic [3:0]              r_cols;
  logic [15:0]             r_scan;
  state_t                  r_state;
  logic [3:0]              r_cnt;
  logic [3:0]              r_cand;
  logic [3:0]              r_key_code;
  logic                    r_key_valid;
  logic                    r_key_pressed;

  logic                    w_tick;
  logic                    w_scan_done;
  logic [1:0]              w_col_next;
  logic [15:0]             w_scan_next;
  logic                    w_empty;
  logic                    w_multi;
  logic                    w_single;
  logic                    w_seen;
  logic [3:0]              w_cand;
  logic [3:0]              w_cnt_inc;

  // ---- stage p0/p1: two-flop row synchroniser (idles at "no row pulled low")
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_rows_p0 <= 4'b1111;
      r_rows_p1 <= 4'b1111;
    end else begin
      r_rows_p0 <= rows;
      r_rows_p1 <= r_rows_p0;
    end
  end

  // ---- column timing: free-running prescaler, one tick per column slot
  assign w_tick      = &r_presc;
  assign w_scan_done = w_tick && (r_col == 2'd3);
  assign w_col_next  = r_col + 2'd1;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_presc <= '0;
      r_col   <= 2'd0;
      r_cols  <= 4'b1110;
      r_scan  <= 16'h0000;
    end else begin
      r_presc <= r_presc + COUNTER_BITS'(1);
      if (w_tick) begin
        r_scan <= w_scan_next;
        r_col  <= w_col_next;
        r_cols <= ~(4'b0001 << w_col_next);
      end
    end
  end

  // Scan vector with the current column's rows merged in; on scan_done this is
  // the completed vector the FSM judges, so no extra cycle of latency.
  always_comb begin
    w_scan_next = r_scan;
    for (int r = 0; r < 4; r++) begin
      w_scan_next[4*r + int'(r_col)] = ~r_rows_p1[r];
    end
  end

  // ---- classify the completed scan: empty / single key / several keys
  always_comb begin
    w_seen  = 1'b0;
    w_multi = 1'b0;
    w_cand  = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (w_scan_next[i]) begin
        if (w_seen) w_multi = 1'b1;
        w_seen = 1'b1;
        w_cand = 4'(i);
      end
    end
  end

  assign w_empty   = ~w_seen;
  assign w_single  = w_seen && !w_multi;
  assign w_cnt_inc = r_cnt + 4'd1;

  // ---- debounce FSM, evaluated once per completed scan; outputs registered
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state       <= S_IDLE;
      r_cnt         <= 4'd0;
      r_cand        <= 4'd0;
      r_key_code    <= 4'd0;
      r_key_valid   <= 1'b0;
      r_key_pressed <= 1'b0;
    end else begin
      // Scans complete at most once every 4 clks, so this default keeps the
      // strobe to a single clk and never back-to-back.
      r_key_valid <= 1'b0;
      if (w_scan_done) begin
        case (r_state)
          S_IDLE: begin
            if (w_single) begin
              r_cand <= w_cand;
              if (DEB_N == 4'd1) begin
                r_cnt         <= 4'd0;
                r_key_code    <= w_cand;
                r_key_valid   <= 1'b1;
                r_key_pressed <= 1'b1;
                r_state       <= S_PRESSED;
              end else begin
                r_cnt   <= 4'd1;
                r_state <= S_DEB_PRESS;
              end
            end
          end

          S_DEB_PRESS: begin
            if (w_single) begin
              if (w_cand == r_cand) begin
                if (w_cnt_inc == DEB_N) begin
                  r_cnt         <= 4'd0;
                  r_key_code    <= r_cand;
                  r_key_valid   <= 1'b1;
                  r_key_pressed <= 1'b1;
                  r_state       <= S_PRESSED;
                end else begin
                  r_cnt <= w_cnt_inc;
                end
              end else begin
                // A different single key restarts the count on the new key.
                r_cand <= w_cand;
                r_cnt  <= 4'd1;
              end
            end else begin
              r_cnt   <= 4'd0;
              r_state <= S_IDLE;
            end
          end

          S_PRESSED: begin
            // Extra keys while held are ignored: no rollover.
            if (w_empty) begin
              if (DEB_N == 4'd1) begin
                r_cnt         <= 4'd0;
                r_key_pressed <= 1'b0;
                r_state       <= S_IDLE;
              end else begin
                r_cnt   <= 4'd1;
                r_state <= S_DEB_RELEASE;
              end
            end
          end

          S_DEB_RELEASE: begin
            if (w_empty) begin
              if (w_cnt_inc == DEB_N) begin
                r_cnt         <= 4'd0;
                r_key_pressed <= 1'b0;
                r_state       <= S_IDLE;
              end else begin
                r_cnt <= w_cnt_inc;
              end
            end else begin
              // Contact bounce on release: back to held, no new strobe.
              r_cnt   <= 4'd0;
              r_state <= S_PRESSED;
            end
          end

          default: begin
            r_cnt   <= 4'd0;
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

  assign cols        = r_cols;
  assign key_code    = r_key_code;
  assign key_valid   = r_key_valid;
  assign key_pressed = r_key_pressed;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Bench for keypad_matrix_scanner with COUNTER_BITS=2 (4-clk slots, 16-clk
// scans) and DEBOUNCE_SCANS=2. A keypad model pulls rows low from the set of
// held keys and the driven columns. Expected key codes are queued when a
// press is stimulated; a monitor pops and compares on every key_valid.
module tb_keypad_matrix_scanner;

  logic       clk;
  logic       nreset;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_pressed;

  logic [15:0] keys;       // held keys, bit index = 4*row + col
  logic [3:0]  exp_q[$];
  int          checks;
  int          errors;
  int          n_valid;

  keypad_matrix_scanner #(
    .COUNTER_BITS  (2),
    .DEBOUNCE_SCANS(2)
  ) dut (
    .clk        (clk),
    .nreset     (nreset),
    .rows       (rows),
    .cols       (cols),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_pressed(key_pressed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Passive matrix: a row reads low if any held key on it sits on a low column.
  always_comb begin
    rows = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[4*r + c] && !cols[c]) rows[r] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    logic last_v;
    logic [3:0] e;
    last_v = 1'b0;
    forever begin
      @(negedge clk);
      if (nreset && key_valid) begin
        n_valid++;
        chk("valid_not_back_to_back", {31'd0, last_v}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_key_valid: got code %0h expected no pulse", key_code);
        end else begin
          e = exp_q.pop_front();
          chk("key_code_on_valid", {28'd0, key_code}, {28'd0, e});
          chk("pressed_on_valid", {31'd0, key_pressed}, 32'd1);
        end
      end
      last_v = nreset && key_valid;
    end
  endtask

  // Wait until the column drive wraps 0111 -> 1110, i.e. one full scan ended.
  task automatic next_scan();
    logic [3:0] prev;
    bit         done;
    prev = cols;
    done = 0;
    for (int i = 0; i < 64 && !done; i++) begin
      @(posedge clk);
      #1;
      if (cols == 4'b1110 && prev == 4'b0111) done = 1;
      prev = cols;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL scan_timeout: got no scan wrap expected one within 64 clks");
    end
  endtask

  task automatic scans(input logic [15:0] k, input int n);
    keys = k;
    for (int i = 0; i < n; i++) next_scan();
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    n_valid = 0;
    keys    = 16'h0000;
    nreset  = 1'b0;
    fork monitor(); join_none

    // Reset with rows toggling
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      keys = 16'($urandom);
    end
    #1;
    chk("rst_cols", {28'd0, cols}, 32'h0000000e);
    chk("rst_code", {28'd0, key_code}, 32'd0);
    chk("rst_valid", {31'd0, key_valid}, 32'd0);
    chk("rst_pressed", {31'd0, key_pressed}, 32'd0);
    keys = 16'h0000;
    @(negedge clk);
    nreset = 1'b1;

    // Column stepping every 4 clks
    repeat (4) @(posedge clk); #1;
    chk("cols_step1", {28'd0, cols}, 32'hd);
    repeat (4) @(posedge clk); #1;
    chk("cols_step2", {28'd0, cols}, 32'hb);
    repeat (4) @(posedge clk); #1;
    chk("cols_step3", {28'd0, cols}, 32'h7);
    repeat (4) @(posedge clk); #1;
    chk("cols_wrap", {28'd0, cols}, 32'he);

    // Clean press of key 6 (row1/col2)
    exp_q.push_back(4'd6);
    scans(16'h0040, 1);
    chk("clean_pressed_after1", {31'd0, key_pressed}, 32'd0);
    scans(16'h0040, 1);
    chk("clean_pressed_after2", {31'd0, key_pressed}, 32'd1);
    scans(16'h0040, 3);
    chk("clean_hold_code", {28'd0, key_code}, 32'd6);
    chk("clean_hold_pressed", {31'd0, key_pressed}, 32'd1);

    // Clean release
    scans(16'h0000, 1);
    chk("release_after1", {31'd0, key_pressed}, 32'd1);
    scans(16'h0000, 1);
    chk("release_after2", {31'd0, key_pressed}, 32'd0);
    chk("release_code_held", {28'd0, key_code}, 32'd6);

    // Bounce on press: alternate scans never accept
    for (int i = 0; i < 3; i++) begin
      scans(16'h0040, 1);
      scans(16'h0000, 1);
    end
    chk("bounce_not_pressed", {31'd0, key_pressed}, 32'd0);
    exp_q.push_back(4'd6);
    scans(16'h0040, 2);
    chk("bounce_then_pressed", {31'd0, key_pressed}, 32'd1);

    // Release with bounce: empty, pressed, empty, empty
    scans(16'h0000, 1);
    scans(16'h0040, 1);
    chk("relbounce_repress", {31'd0, key_pressed}, 32'd1);
    scans(16'h0000, 1);
    chk("relbounce_empty1", {31'd0, key_pressed}, 32'd1);
    scans(16'h0000, 1);
    chk("relbounce_released", {31'd0, key_pressed}, 32'd0);

    // Multi-key from idle: keys 0 and 15 together
    scans(16'h8001, 3);
    chk("multi_idle_pressed", {31'd0, key_pressed}, 32'd0);
    scans(16'h0000, 1);
    exp_q.push_back(4'd6);
    scans(16'h0040, 2);
    scans(16'h8040, 2);
    chk("multi_held_code", {28'd0, key_code}, 32'd6);
    chk("multi_held_pressed", {31'd0, key_pressed}, 32'd1);
    scans(16'h0000, 2);
    chk("multi_released", {31'd0, key_pressed}, 32'd0);

    // Async reset in the middle of press debounce
    scans(16'h0040, 1);
    repeat (5) @(posedge clk);
    #2;
    nreset = 1'b0;
    #1;
    chk("midrst_cols", {28'd0, cols}, 32'he);
    chk("midrst_code", {28'd0, key_code}, 32'd0);
    chk("midrst_pressed", {31'd0, key_pressed}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    nreset = 1'b1;
    exp_q.push_back(4'd6);
    scans(16'h0040, 1);
    chk("midrst_after1_pressed", {31'd0, key_pressed}, 32'd0);
    chk("midrst_after1_pending", exp_q.size(), 32'd1);
    scans(16'h0040, 1);
    chk("midrst_after2_pressed", {31'd0, key_pressed}, 32'd1);
    chk("midrst_after2_code", {28'd0, key_code}, 32'd6);
    scans(16'h0000, 2);

    chk("queue_drained", exp_q.size(), 32'd0);
    chk("valid_count", n_valid, 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_matrix_scanner.md
Name: keypad_matrix_scanner

Overview:
Reads a 4x4 passive matrix keypad: drives one column low at a time and samples the pulled-up row lines, the same time-multiplexing scheme our seven-segment display driver uses. Synchronises and debounces the rows, then reports a single pressed key as a 4-bit code with a one-cycle valid strobe and a held level. Sits between the PMOD header pins and user logic such as counters or display code inputs.

Parameters:
COUNTER_BITS, 18, prescaler width; one column slot lasts 2^COUNTER_BITS clk cycles
DEBOUNCE_SCANS, 3, consecutive identical full scans needed to accept a press or a release (legal range 1..15)

Ports:
clk  input  1  system clock
nreset  input  1  asynchronous, active-low reset
rows  input  4  keypad row lines, active low (external pull-ups), asynchronous to clk
cols  output  4  column drive, active low, exactly one bit low at any time
key_code  output  4  code of the accepted key = 4*row + col
key_valid  output  1  one-clk pulse when a new press is accepted
key_pressed  output  1  high while the accepted key is held

Behaviour:
- Reset (async, nreset=0): prescaler=0, col index=0, cols=4'b1110, scan vector=0, state=IDLE, debounce count=0, key_code=0, key_valid=0, key_pressed=0. The 2-flop row synchroniser resets to 4'b1111. Reset mid-scan abandons the partial scan with no output pulse.
- Prescaler counts every clk and wraps. tick = prescaler==all-ones.
- On tick: store ~rows_sync into scan vector bits [4*r+c] for current column c, then advance c (3 wraps to 0). cols = ~(1<<c) is registered and changes on the clk after tick.
- scan_done = tick with c==3. This completes a 16-bit scan vector S.
- Classify S: EMPTY (S==0), SINGLE (exactly one bit, candidate = its index), MULTI (two or more bits).
- FSM evaluates only on scan_done. Outputs are registered and visible on the clk after scan_done.
  IDLE: on SINGLE, latch cand and set cnt=1. If DEBOUNCE_SCANS==1, go to PRESSED (accept). Otherwise go to DEB_PRESS. On EMPTY or MULTI, stay in IDLE.
  DEB_PRESS: on SINGLE with the same cand, cnt+1; on reaching DEBOUNCE_SCANS, go to PRESSED (accept). On SINGLE with a different key, cand=new and cnt=1. On EMPTY or MULTI, go to IDLE with cnt=0.
  Accept: key_code=cand, key_valid=1 for exactly one clk, key_pressed=1.
  PRESSED: on EMPTY, cnt=1 and go to DEB_RELEASE; if DEBOUNCE_SCANS==1, release immediately. On SINGLE or MULTI (including a different key), stay in PRESSED and keep key_code. There is no rollover.
  DEB_RELEASE: on EMPTY, cnt+1; on reaching DEBOUNCE_SCANS, go to IDLE and set key_pressed=0. On any non-empty scan, go back to PRESSED with no new key_valid.
- key_code holds its last accepted value after release.
- key_valid is never asserted in two consecutive clks.
- Latency from the first clean scan to key_valid: DEBOUNCE_SCANS full scans + 1 clk.

Test Plan:
- Reset: nreset=0 with rows toggling -> cols=1110, key_code=0, key_valid=0, key_pressed=0. On release, cols steps 1110->1101->1011->0111 every 2^COUNTER_BITS clks.
- Clean press (COUNTER_BITS=2, DEBOUNCE_SCANS=2): hold key row1/col2, i.e. rows[1]=0 while cols[2]=0 -> exactly one key_valid pulse, key_code=6, key_pressed=1 one clk after the 2nd complete scan (~32 clks). No further pulses while held.
- Bounce: toggle the row1/col2 contact on alternate scans -> no key_valid. Then hold steady for 2 scans -> single key_valid with key_code=6.
- Release with bounce: from PRESSED, one empty scan, then one pressed scan, then 2 empty scans -> key_pressed drops only after the final 2 empty scans. No key_valid is generated on the re-press.
- Multi-key: from IDLE press row0/col0 and row3/col3 together -> no key_valid. While key 6 is PRESSED, add key 15 -> key_code stays 6 and key_pressed stays 1.
- Async reset mid-debounce: assert nreset during DEB_PRESS -> outputs return to reset values immediately. After release, a fresh 2-scan debounce is required before key_valid.
